// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: streams one stored RGB565 frame as a valid/ready pixel stream.
// Optional FBR_CONTINUOUS_EN: frames repeat back-to-back after a single start.
module frame_buffer_reader #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] rAddr,
  input  logic [15:0]           rData,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [15:0]           m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] A_LAST =
    ADDR_WIDTH'(IMG_WIDTH*IMG_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [ADDR_WIDTH-1:0] addr;
  logic [2:0]            re_flags;
  logic                  rv;
  logic [2:0]            rv_flags;
  logic [1:0]            count;
  logic [15:0]           head_data;
  logic [15:0]           tail_data;
  logic [2:0]            head_flags;
  logic [2:0]            tail_flags;

  logic                  pop;
  logic                  start_ok;
  logic                  issue;
  logic [2:0]            pending;
  logic [XW-1:0]         cx;
  logic [YW-1:0]         cy;
  logic [ADDR_WIDTH-1:0] ca;
  logic [2:0]            iflags;

  assign m_valid = (count != 2'd0);
  assign m_data  = head_data;
  assign m_sof   = head_flags[2];
  assign m_eol   = head_flags[1];
  assign m_eof   = head_flags[0];

  // Read issue decision: counters start from zero on an accepted start,
  // and a read is only issued if its data is guaranteed a FIFO slot.
  always_comb begin
    pop      = m_valid & m_ready;
    pending  = {1'b0, count} + {2'b0, rv} + {2'b0, re} - {2'b0, pop};
    start_ok = (state == S_IDLE) & start;
    issue    = start_ok | ((state == S_READ) & (pending < 3'd2));
    cx       = start_ok ? '0 : x;
    cy       = start_ok ? '0 : y;
    ca       = start_ok ? '0 : addr;
    iflags   = {(cx == '0) && (cy == '0),
                cx == X_LAST,
                (cx == X_LAST) && (cy == Y_LAST)};
  end

  // Frame sequencing, address generation and read port registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      re       <= 1'b0;
      rAddr    <= '0;
      re_flags <= '0;
      x        <= '0;
      y        <= '0;
      addr     <= '0;
    end else begin
      re   <= issue;
      done <= 1'b0;
      if (issue) begin
        rAddr    <= ca;
        re_flags <= iflags;
        addr     <= ca + 1'b1;
        if (cx == X_LAST) begin
          x <= '0;
          y <= cy + 1'b1;
        end else begin
          x <= cx + 1'b1;
          y <= cy;
        end
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= (ca == A_LAST) ? S_DRAIN : S_READ;
            busy  <= 1'b1;
          end
        end
        S_READ: begin
          if (issue && (ca == A_LAST)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((count == 2'd0) && !rv && !re) begin
            state <= S_DONE;
            done  <= 1'b1;
`ifndef FBR_CONTINUOUS_EN
            busy  <= 1'b0;
`endif
          end
        end
        S_DONE: begin
`ifdef FBR_CONTINUOUS_EN
          state <= S_READ;
          addr  <= '0;
          x     <= '0;
          y     <= '0;
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Return-data alignment and the 2-entry output FIFO (head drives outputs).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv         <= 1'b0;
      rv_flags   <= '0;
      count      <= 2'd0;
      head_data  <= '0;
      head_flags <= '0;
      tail_data  <= '0;
      tail_flags <= '0;
    end else begin
      rv       <= re;
      rv_flags <= re_flags;
      unique case ({rv, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data  <= rData;
            head_flags <= rv_flags;
          end else begin
            tail_data  <= rData;
            tail_flags <= rv_flags;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data  <= tail_data;
          head_flags <= tail_flags;
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_data  <= rData;
            head_flags <= rv_flags;
          end else begin
            head_data  <= tail_data;
            head_flags <= tail_flags;
            tail_data  <= rData;
            tail_flags <= rv_flags;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb_frame_buffer_reader: scoreboard bench for frame_buffer_reader on a 4x3 frame.
// Buffer model returns the address as pixel data, one clock after re.
module tb_frame_buffer_reader;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);
`ifdef FBR_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          m_ready = 1'b0;
  logic          busy, done, re, m_valid, m_sof, m_eol, m_eof;
  logic [AW-1:0] rAddr;
  logic [15:0]   rData = '0;
  logic [15:0]   m_data;
  logic [15:0]   mem [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int nreads = 0;
  int done_cnt = 0;
  int last_hs = 0;
  int outst = 0;
  int rdy_mode = 0;
  bit prev_stall = 1'b0;
  logic [19:0] prev_vec = '0;
  logic [18:0] exp_q [$];
  logic [18:0] e;

  frame_buffer_reader #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .re     (re),
    .rAddr  (rAddr),
    .rData  (rData),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_sof  (m_sof),
    .m_eol  (m_eol),
    .m_eof  (m_eof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (re) rData <= mem[rAddr];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      outst      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stable", 32'({m_valid, m_data, m_sof, m_eol, m_eof}),
              32'(prev_vec));
      if (re) begin
        nreads++;
        outst++;
        check("occupancy", 32'(outst > 2), 32'(0));
      end
      if (m_valid && m_ready) begin
        check("q_nonempty", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pix", 32'({m_data, m_sof, m_eol, m_eof}), 32'(e));
        end
        hs_cnt++;
        last_hs = cyc;
        outst--;
      end
      if (done) begin
        done_cnt++;
        check("done_lat", 32'(cyc - last_hs), 32'(2));
        check("done_busy", 32'(busy), 32'(CONT));
      end
      prev_stall = m_valid && !m_ready;
      prev_vec   = {m_valid, m_data, m_sof, m_eol, m_eof};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  task automatic push_frame();
    for (int i = 0; i < N; i++)
      exp_q.push_back({16'(i), i == 0, (i % W) == W - 1, i == N - 1});
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 1000) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("done_seen", 32'(done_cnt >= target), 32'(1));
  endtask

  task automatic wait_hs(input int target);
    int k;
    k = 0;
    while (hs_cnt < target && k < 1000) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("hs_seen", 32'(hs_cnt >= target), 32'(1));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"},  32'(busy),    32'(0));
    check({tag, "_done"},  32'(done),    32'(0));
    check({tag, "_re"},    32'(re),      32'(0));
    check({tag, "_raddr"}, 32'(rAddr),   32'(0));
    check({tag, "_valid"}, 32'(m_valid), 32'(0));
    check({tag, "_data"},  32'(m_data),  32'(0));
    check({tag, "_sof"},   32'(m_sof),   32'(0));
    check({tag, "_eol"},   32'(m_eol),   32'(0));
    check({tag, "_eof"},   32'(m_eof),   32'(0));
  endtask

  task automatic test_basic();
    int base;
    rdy_mode = 0;
    base = done_cnt;
    push_frame();
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    check("t0_busy", 32'(busy), 32'(0));
    check("t0_re", 32'(re), 32'(0));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t1_re", 32'(re), 32'(1));
    check("t1_raddr", 32'(rAddr), 32'(0));
    check("t1_busy", 32'(busy), 32'(1));
    @(negedge clk);
    check("t2_valid", 32'(m_valid), 32'(0));
    @(negedge clk);
    check("t3_valid", 32'(m_valid), 32'(1));
    check("t3_data", 32'(m_data), 32'(0));
    check("t3_sof", 32'(m_sof), 32'(1));
    wait_done(base + 1);
    @(negedge clk);
    check("basic_q", 32'(exp_q.size()), 32'(0));
    check("basic_idle", 32'(busy), 32'(0));
  endtask

  task automatic test_random();
    int base;
    rdy_mode = 1;
    base = done_cnt;
    push_frame();
    pulse_start();
    wait_done(base + 1);
    @(negedge clk);
    check("rand_q", 32'(exp_q.size()), 32'(0));
    rdy_mode = 0;
  endtask

  task automatic test_stall();
    int base;
    int r0;
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    base = done_cnt;
    r0 = nreads;
    push_frame();
    pulse_start();
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("stall_reads", 32'(nreads - r0), 32'(2));
    check("stall_valid", 32'(m_valid), 32'(1));
    check("stall_data", 32'(m_data), 32'(0));
    rdy_mode = 0;
    wait_done(base + 1);
    @(negedge clk);
    check("stall_q", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic test_restart();
    int base;
    rdy_mode = 0;
    base = done_cnt;
    push_frame();
    pulse_start();
    wait_hs(hs_cnt + 5);
    pulse_start();
    wait_done(base + 1);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("restart_dones", 32'(done_cnt - base), 32'(1));
    check("restart_q", 32'(exp_q.size()), 32'(0));
    check("restart_valid", 32'(m_valid), 32'(0));
    check("restart_busy", 32'(busy), 32'(0));
  endtask

  task automatic test_reset();
    int base;
    rdy_mode = 0;
    base = done_cnt;
    push_frame();
    pulse_start();
    wait_hs(hs_cnt + 5);
    reset = 1'b1;
    #1;
    check_reset_outs("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("midrst_nodone", 32'(done_cnt - base), 32'(0));
    push_frame();
    pulse_start();
    wait_done(base + 1);
    @(negedge clk);
    check("midrst_q", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic test_cont();
    int base;
    int h0;
    rdy_mode = 0;
    base = done_cnt;
    h0 = hs_cnt;
    for (int f = 0; f < 3; f++) push_frame();
    pulse_start();
    wait_done(base + 3);
    reset = 1'b1;
    #1;
    check("cont_dones", 32'(done_cnt - base), 32'(3));
    check("cont_pixels", 32'(hs_cnt - h0), 32'(3 * N));
    check("cont_q", 32'(exp_q.size()), 32'(0));
    check_reset_outs("contrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 16'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset");
    @(posedge clk);
    #1 reset = 1'b0;
`ifdef FBR_CONTINUOUS_EN
    test_cont();
`else
    test_basic();
    test_random();
    test_stall();
    test_restart();
    test_reset();
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
